mic1_mem_ctrl: RTL and testbench

Memory-side responder for the MIC-1 datapath. It accepts the microinstruction's rd/wr/fetch strobes together with MAR, MDR and PC contents. It then runs a req/ack handshake against a single-port word-addressed main memory and returns read data as load pulses into MDR (32-bit) and MBR (8-bit). It asserts busy to stall the microsequencer while any access is outstanding.

---
 rtl/mic1_mem_ctrl_pkg.sv | 27 ++
 rtl/mic1_mem_timeout.sv | 28 ++
 rtl/mic1_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_mic1_mem_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mic1_mem_ctrl_pkg.sv
// Shared definitions for the MIC-1 memory controller.
// Includes state encoding, handshake widths and byte-lane selection.
package mic1_mem_ctrl_pkg;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned TMO_WIDTH  = 16;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DATA_REQ  = 2'd1;
  localparam logic [1:0] ST_FETCH_REQ = 2'd2;

  // Lane 0 is the least significant byte of the word.
  function automatic logic [BYTE_WIDTH-1:0] byte_lane(input logic [WORD_WIDTH-1:0] word,
                                                      input logic [1:0]            sel);
    logic [BYTE_WIDTH-1:0] lane;
    case (sel)
      2'd0:    lane = word[7:0];
      2'd1:    lane = word[15:8];
      2'd2:    lane = word[23:16];
      2'd3:    lane = word[31:24];
      default: lane = 8'd0;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/mic1_mem_timeout.sv
// Loadable down-counter that flags expiry when it reaches zero.
module mic1_mem_timeout #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count_r;

  // Count down while enabled, saturating at zero; a load restarts the window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign expired = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/mic1_mem_ctrl.sv
// MIC-1 memory responder: turns rd/wr/fetch strobes into req/ack memory
// accesses and returns read data as MDR/MBR load pulses.
module mic1_mem_ctrl
  import mic1_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_WIDTH     = 30
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic                  fetch,
  input  logic [WORD_WIDTH-1:0] marIn,
  input  logic [WORD_WIDTH-1:0] mdrIn,
  input  logic [WORD_WIDTH-1:0] pcIn,
  output logic [WORD_WIDTH-1:0] mdrOut,
  output logic                  mdrLoad,
  output logic [BYTE_WIDTH-1:0] mbrOut,
  output logic                  mbrLoad,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [WORD_WIDTH-1:0] memWData,
  output logic                  memWe,
  output logic                  memReq,
  input  logic [WORD_WIDTH-1:0] memRData,
  input  logic                  memAck,
  output logic                  protocolError
);

  localparam logic [TMO_WIDTH-1:0] TMO_LOAD = TMO_WIDTH'(TIMEOUT_CYCLES - 32'd1);

  logic [1:0]            state_r;
  logic [ADDR_WIDTH+1:0] pc_r;
  logic                  pend_wr_r;
  logic                  pend_fetch_r;
  logic                  any_strobe_s;
  logic                  done_s;
  logic                  abort_s;
  logic                  issue_s;
  logic                  err_s;
  logic                  tmo_expired_s;
  logic                  unused_bits_s;

  assign any_strobe_s  = rd | wr | fetch;
  assign done_s        = memReq & memAck;
  assign abort_s       = memReq & ~memAck & tmo_expired_s;
  assign unused_bits_s = ^{marIn, pcIn};

  // A new request starts from IDLE, or from the idle gap cycle before a fetch.
  always_comb begin
    issue_s = 1'b0;
    case (state_r)
      ST_IDLE:      issue_s = any_strobe_s;
      ST_FETCH_REQ: issue_s = ~memReq;
      default:      issue_s = 1'b0;
    endcase
  end

  // Illegal strobe use: any strobe while busy, or rd and wr together when idle.
  always_comb begin
    if (busy) begin
      err_s = abort_s | any_strobe_s;
    end else begin
      err_s = abort_s | (rd & wr);
    end
  end

  mic1_mem_timeout #(
    .WIDTH(TMO_WIDTH)
  ) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .load       (issue_s),
    .load_value (TMO_LOAD),
    .enable     (memReq),
    .expired    (tmo_expired_s)
  );

  // Access sequencer; an aborted access completes as if it returned zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      pc_r          <= {(ADDR_WIDTH+2){1'b0}};
      pend_wr_r     <= 1'b0;
      pend_fetch_r  <= 1'b0;
      mdrOut        <= 32'd0;
      mdrLoad       <= 1'b0;
      mbrOut        <= 8'd0;
      mbrLoad       <= 1'b0;
      busy          <= 1'b0;
      memAddr       <= {ADDR_WIDTH{1'b0}};
      memWData      <= 32'd0;
      memWe         <= 1'b0;
      memReq        <= 1'b0;
      protocolError <= 1'b0;
    end else begin
      mdrLoad       <= 1'b0;
      mbrLoad       <= 1'b0;
      protocolError <= err_s;
      case (state_r)
        ST_IDLE: begin
          if (any_strobe_s) begin
            pc_r         <= pcIn[ADDR_WIDTH+1:0];
            pend_wr_r    <= wr;
            pend_fetch_r <= fetch;
            busy         <= 1'b1;
            memReq       <= 1'b1;
            if (rd | wr) begin
              state_r  <= ST_DATA_REQ;
              memAddr  <= marIn[ADDR_WIDTH-1:0];
              memWe    <= wr;
              memWData <= mdrIn;
            end else begin
              state_r  <= ST_FETCH_REQ;
              memAddr  <= pcIn[ADDR_WIDTH+1:2];
              memWe    <= 1'b0;
            end
          end
        end
        ST_DATA_REQ: begin
          if (done_s || abort_s) begin
            memReq <= 1'b0;
            memWe  <= 1'b0;
            if (!pend_wr_r) begin
              mdrLoad <= 1'b1;
              mdrOut  <= done_s ? memRData : 32'd0;
            end
            if (pend_fetch_r) begin
              state_r <= ST_FETCH_REQ;
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        ST_FETCH_REQ: begin
          if (!memReq) begin
            memReq  <= 1'b1;
            memAddr <= pc_r[ADDR_WIDTH+1:2];
            memWe   <= 1'b0;
          end else if (done_s || abort_s) begin
            memReq  <= 1'b0;
            mbrLoad <= 1'b1;
            mbrOut  <= done_s ? byte_lane(memRData, pc_r[1:0]) : 8'd0;
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          memReq  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// Directed bench for mic1_mem_ctrl; load pulses are checked against a
// scoreboard of expected MDR/MBR values.
module tb_mic1_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0, wr = 1'b0, fetch = 1'b0;
  logic [31:0] marIn = 32'd0, mdrIn = 32'd0, pcIn = 32'd0;
  logic [31:0] mdrOut;
  logic        mdrLoad;
  logic [7:0]  mbrOut;
  logic        mbrLoad;
  logic        busy;
  logic [29:0] memAddr;
  logic [31:0] memWData;
  logic        memWe;
  logic        memReq;
  logic [31:0] memRData = 32'd0;
  logic        memAck = 1'b0;
  logic        protocolError;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic is_mbr; logic [31:0] data; } exp_t;
  exp_t sb_q[$];

  mic1_mem_ctrl #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(30)) dut (
    .clock(clock), .reset(reset), .rd(rd), .wr(wr), .fetch(fetch),
    .marIn(marIn), .mdrIn(mdrIn), .pcIn(pcIn),
    .mdrOut(mdrOut), .mdrLoad(mdrLoad), .mbrOut(mbrOut), .mbrLoad(mbrLoad),
    .busy(busy), .memAddr(memAddr), .memWData(memWData), .memWe(memWe),
    .memReq(memReq), .memRData(memRData), .memAck(memAck),
    .protocolError(protocolError)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic r, input logic w, input logic f,
                        input logic [31:0] mar, input logic [31:0] mdr, input logic [31:0] pc);
    rd = r; wr = w; fetch = f; marIn = mar; mdrIn = mdr; pcIn = pc;
    step();
    rd = 1'b0; wr = 1'b0; fetch = 1'b0;
  endtask

  // Memory side: hold the request for 'waits' cycles then ack; poke issues a
  // stray rd strobe in the first request cycle.
  task automatic serve(input string tag, input int waits, input logic [31:0] rdata,
                       input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic poke);
    for (int i = 0; i <= waits; i++) begin
      chk({tag, "_req"}, 32'(memReq), 32'd1);
      chk({tag, "_addr"}, 32'(memAddr), addr);
      chk({tag, "_we"}, 32'(memWe), 32'(we));
      if (we) chk({tag, "_wdata"}, memWData, wdata);
      if (i == 1) chk({tag, "_perr"}, 32'(protocolError), 32'(poke));
      rd = (i == 0) ? poke : 1'b0;
      if (i == waits) begin
        memAck = 1'b1;
        memRData = rdata;
      end
      step();
      memAck = 1'b0; memRData = 32'd0; rd = 1'b0;
    end
  endtask

  // Scoreboard: every load pulse must match the oldest expected entry.
  always @(negedge clock) begin
    exp_t e;
    if (reset && (mdrLoad || mbrLoad)) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed load mdr=%0b mbr=%0b expected none", mdrLoad, mbrLoad);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_kind", 32'(mbrLoad), 32'(e.is_mbr));
        chk("sb_data", mbrLoad ? {24'd0, mbrOut} : mdrOut, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(); step();
    chk("rst_mdrOut", mdrOut, 32'd0);
    chk("rst_mbrOut", 32'(mbrOut), 32'd0);
    chk("rst_memAddr", 32'(memAddr), 32'd0);
    chk("rst_memWData", memWData, 32'd0);
    chk("rst_ctl", {25'd0, memWe, memReq, mdrLoad, mbrLoad, busy, protocolError, 1'b0}, 32'd0);
    reset = 1'b1;
    step();

    // Plain read, zero wait states
    sb_q.push_back({1'b0, 32'hDEADBEEF});
    strobe(1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 32'd0);
    chk("rd_busy_hi", 32'(busy), 32'd1);
    serve("rd", 0, 32'hDEADBEEF, 32'h10, 1'b0, 32'd0, 1'b0);
    chk("rd_load", 32'(mdrLoad), 32'd1);
    chk("rd_busy_lo", 32'(busy), 32'd0);
    chk("rd_req_lo", 32'(memReq), 32'd0);
    chk("rd_perr", 32'(protocolError), 32'd0);
    step();
    chk("rd_load_once", 32'(mdrLoad), 32'd0);

    // Write with 3 wait states and a stray strobe while busy
    strobe(1'b0, 1'b1, 1'b0, 32'h4, 32'h12345678, 32'd0);
    serve("wr", 3, 32'd0, 32'h4, 1'b1, 32'h12345678, 1'b1);
    chk("wr_busy_lo", 32'(busy), 32'd0);
    chk("wr_req_lo", 32'(memReq), 32'd0);
    chk("wr_no_tmo", 32'(protocolError), 32'd0);
    chk("wr_no_load", 32'(mdrLoad), 32'd0);
    step();

    // Byte fetch, top lane
    sb_q.push_back({1'b1, 32'h000000AA});
    strobe(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h103);
    serve("fetch", 0, 32'hAABBCCDD, 32'h40, 1'b0, 32'd0, 1'b0);
    chk("fetch_load", 32'(mbrLoad), 32'd1);
    chk("fetch_busy_lo", 32'(busy), 32'd0);
    step();

    // Combined read + fetch
    sb_q.push_back({1'b0, 32'hCAFEF00D});
    sb_q.push_back({1'b1, 32'h00000033});
    strobe(1'b1, 1'b0, 1'b1, 32'h8, 32'd0, 32'h21);
    chk("rf_busy1", 32'(busy), 32'd1);
    serve("rf_data", 0, 32'hCAFEF00D, 32'h8, 1'b0, 32'd0, 1'b0);
    chk("rf_gap", 32'(memReq), 32'd0);
    chk("rf_busy2", 32'(busy), 32'd1);
    chk("rf_mdrload", 32'(mdrLoad), 32'd1);
    step();
    serve("rf_fetch", 0, 32'h11223344, 32'h8, 1'b0, 32'd0, 1'b0);
    chk("rf_mbrload", 32'(mbrLoad), 32'd1);
    chk("rf_busy_lo", 32'(busy), 32'd0);
    step();

    // Read with no ack: aborted after 4 request cycles
    sb_q.push_back({1'b0, 32'd0});
    strobe(1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req_hold", 32'(memReq), 32'd1);
      step();
    end
    chk("tmo_req_lo", 32'(memReq), 32'd0);
    chk("tmo_perr", 32'(protocolError), 32'd1);
    chk("tmo_load", 32'(mdrLoad), 32'd1);
    chk("tmo_busy_lo", 32'(busy), 32'd0);
    step();
    chk("tmo_perr_pulse", 32'(protocolError), 32'd0);

    // rd and wr together: performed as a write, flagged
    strobe(1'b1, 1'b1, 1'b0, 32'h30, 32'h55AA55AA, 32'd0);
    chk("rdwr_perr", 32'(protocolError), 32'd1);
    serve("rdwr", 0, 32'd0, 32'h30, 1'b1, 32'h55AA55AA, 1'b0);
    chk("rdwr_busy_lo", 32'(busy), 32'd0);
    chk("rdwr_no_load", 32'(mdrLoad), 32'd0);
    step();

    // Asynchronous reset mid-access with ack in flight
    strobe(1'b1, 1'b0, 1'b0, 32'h44, 32'd0, 32'd0);
    chk("ar_req_hi", 32'(memReq), 32'd1);
    memAck = 1'b1; memRData = 32'h99;
    #2 reset = 1'b0;
    #1;
    chk("ar_req_async", 32'(memReq), 32'd0);
    chk("ar_busy_async", 32'(busy), 32'd0);
    step();
    reset = 1'b1;
    step();
    memAck = 1'b0; memRData = 32'd0;
    chk("ar_no_load", 32'(mdrLoad), 32'd0);
    chk("ar_idle_req", 32'(memReq), 32'd0);
    chk("ar_idle_busy", 32'(busy), 32'd0);

    // Normal read after reset
    sb_q.push_back({1'b0, 32'h0BADCAFE});
    strobe(1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 32'd0);
    serve("rd2", 0, 32'h0BADCAFE, 32'h10, 1'b0, 32'd0, 1'b0);
    chk("rd2_load", 32'(mdrLoad), 32'd1);
    step();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
